// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, funct codes, ALU operation set and ALU datapath.
package rv_pkg;

    // Major opcodes handled by the core; anything else retires as a NOP
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // funct3 for OP_IMM / OP_REG
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 for OP_BRANCH (010/011 are reserved)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7: base encoding and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    // 32-bit ALU; shifts use the low five bits of b, arithmetic wraps
    function automatic logic [31:0] alu_exec(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: return {31'b0, (a < b)};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/rv_core.sv
// Single-cycle RV32I core: pc, decode, ALU, branch unit and register file.
module rv_core
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ROM_AW   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst,
    output logic [ROM_AW-1:0] fetch_idx
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic        is_reg;
    alu_op_e     alu_op;
    logic        alu_ok;
    logic [31:0] alu_b;
    logic [31:0] alu_y;

    logic        br_eq;
    logic        br_lt_s;
    logic        br_lt_u;
    logic        br_taken;

    logic        rd_we;
    logic [31:0] rd_val;

    // Instruction fields
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    // Sign-extended immediates for the formats the core executes
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'h000};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Upper pc bits are dropped so fetches wrap around the ROM
    assign fetch_idx = pc[ROM_AW+1:2];
    assign pc_plus4  = pc + 32'd4;

    rv_regs regs_ins (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wr_en    (rd_we),
        .wr_addr  (rd),
        .wr_data  (rd_val)
    );

    // ALU operand B: register for R-type, I-immediate otherwise (shamt sits in imm_i[4:0])
    assign is_reg = (opcode == OP_REG);
    assign alu_b  = is_reg ? rs2_val : imm_i;
    assign alu_y  = alu_exec(alu_op, rs1_val, alu_b);

    // Map funct3/funct7 onto an ALU op; reserved funct7 encodings make the instruction a NOP
    always_comb begin
        alu_op = ALU_ADD;
        alu_ok = 1'b0;
        case (funct3)
            F3_ADD: begin
                alu_op = (is_reg && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                alu_ok = !is_reg || funct7 == F7_BASE || funct7 == F7_ALT;
            end
            F3_SLL: begin
                alu_op = ALU_SLL;
                alu_ok = (funct7 == F7_BASE);
            end
            F3_SLT: begin
                alu_op = ALU_SLT;
                alu_ok = !is_reg || funct7 == F7_BASE;
            end
            F3_SLTU: begin
                alu_op = ALU_SLTU;
                alu_ok = !is_reg || funct7 == F7_BASE;
            end
            F3_XOR: begin
                alu_op = ALU_XOR;
                alu_ok = !is_reg || funct7 == F7_BASE;
            end
            F3_SR: begin
                alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                alu_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            end
            F3_OR: begin
                alu_op = ALU_OR;
                alu_ok = !is_reg || funct7 == F7_BASE;
            end
            default: begin
                alu_op = ALU_AND;
                alu_ok = !is_reg || funct7 == F7_BASE;
            end
        endcase
    end

    // Branch comparator
    assign br_eq   = (rs1_val == rs2_val);
    assign br_lt_s = ($signed(rs1_val) < $signed(rs2_val));
    assign br_lt_u = (rs1_val < rs2_val);

    // Branch condition per funct3; reserved codes never branch
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = br_eq;
            F3_BNE:  br_taken = !br_eq;
            F3_BLT:  br_taken = br_lt_s;
            F3_BGE:  br_taken = !br_lt_s;
            F3_BLTU: br_taken = br_lt_u;
            F3_BGEU: br_taken = !br_lt_u;
            default: br_taken = 1'b0;
        endcase
    end

    // Writeback value and next pc; unsupported opcodes fall through as pc+4 with no write
    always_comb begin
        pc_next = pc_plus4;
        rd_we   = 1'b0;
        rd_val  = alu_y;
        case (opcode)
            OP_LUI: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            OP_AUIPC: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                pc_next = pc + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we   = 1'b1;
                    rd_val  = pc_plus4;
                    pc_next = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                if (br_taken) pc_next = pc + imm_b;
            end
            OP_IMM, OP_REG: begin
                rd_we = alu_ok;
            end
            default: begin
                rd_we = 1'b0;
            end
        endcase
    end

    // Program counter; reset returns to RESET_PC immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= pc_next;
    end

endmodule

// File: rtl/rv_regs.sv
// 32 x 32-bit integer register file: two async read ports, one sync write port, x0 hardwired 0.
module rv_regs
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [0:31];

    // Reads are combinational; a same-cycle write is only visible after the edge
    assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : regs[rs2_addr];

    // Register update; reset clears everything, writes to x0 are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/rv_rom.sv
// Word-addressed instruction ROM with combinational read; contents are preloaded externally.
module rv_rom
    import rv_pkg::*;
#(
    parameter int ROM_DEPTH = 4096,
    parameter int ROM_AW    = 12
) (
    input  logic [ROM_AW-1:0] addr,
    output logic [31:0]       inst
);

    logic [31:0] rom_mem [0:ROM_DEPTH-1];

    assign inst = rom_mem[addr];

endmodule

// File: rtl/rv_soc_top.sv
// Minimal SoC: one single-cycle RV32I core fetching from an instruction ROM.
module rv_soc_top
    import rv_pkg::*;
#(
    parameter int          ROM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic rst
);

    localparam int ROM_AW = $clog2(ROM_DEPTH);

    logic [ROM_AW-1:0] fetch_idx;
    logic [31:0]       inst;

    rv_core #(
        .RESET_PC (RESET_PC),
        .ROM_AW   (ROM_AW)
    ) rv_core_ins (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .fetch_idx (fetch_idx)
    );

    rv_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .ROM_AW    (ROM_AW)
    ) rom_ins (
        .addr (fetch_idx),
        .inst (inst)
    );

endmodule

// File: tb/tb_rv_soc_top.sv
// Scoreboard bench for rv_soc_top: an ISA-level model predicts pc and register state per cycle,
// a monitor compares them against the core on the falling edge.
module tb_rv_soc_top;

    localparam int          ROM_DEPTH = 4096;
    localparam logic [31:0] NOP       = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    rv_soc_top #(.ROM_DEPTH(ROM_DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

    // kind 0: pc, kind 1: single register, kind 2: whole register file
    typedef struct {
        int                 cyc;
        string              tag;
        int                 kind;
        int                 idx;
        logic [31:0]        val;
        logic [31:0][31:0]  rf;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;
    logic [31:0] trom  [ROM_DEPTH];
    logic [31:0] mregs [32];
    logic [31:0] mpc;

    // retired-instruction counter since reset release
    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    task automatic check(input exp_t e);
        logic [31:0] got;
        int          bad;
        n_cmp++;
        case (e.kind)
            0: begin
                got = dut.rv_core_ins.pc;
                if (got !== e.val) begin
                    n_bad++;
                    $display("FAIL %s cyc%0d pc: got %h want %h", e.tag, e.cyc, got, e.val);
                end
            end
            1: begin
                got = dut.rv_core_ins.regs_ins.regs[e.idx];
                if (got !== e.val) begin
                    n_bad++;
                    $display("FAIL %s cyc%0d x%0d: got %h want %h", e.tag, e.cyc, e.idx, got, e.val);
                end
            end
            default: begin
                bad = -1;
                for (int i = 31; i >= 0; i--)
                    if (dut.rv_core_ins.regs_ins.regs[i] !== e.rf[i]) bad = i;
                if (bad >= 0) begin
                    n_bad++;
                    $display("FAIL %s cyc%0d regfile x%0d: got %h want %h", e.tag, e.cyc, bad,
                             dut.rv_core_ins.regs_ins.regs[bad], e.rf[bad]);
                end
            end
        endcase
    endtask

    // monitor: consume every expectation stamped with the current cycle
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc == cyc) begin
                check(q[i]);
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d skipped (now %0d)", q[i].tag, q[i].cyc, cyc);
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] i_t(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] u_t(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] b_t(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] j_t(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    // ---------------- reference model (ISA semantics) ----------------
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] s;
        s = v << (32 - bits);
        return 32'($signed(s) >>> (32 - bits));
    endfunction

    task automatic mstep();
        logic [31:0] w, a, b, opb, res, nxt;
        logic [4:0]  rd, sh;
        logic        take, regop, f7_zero, f7_alt;
        bit          wr;
        w       = trom[(mpc >> 2) % ROM_DEPTH];
        rd      = w[11:7];
        a       = mregs[w[19:15]];
        b       = mregs[w[24:20]];
        nxt     = mpc + 32'd4;
        wr      = 1'b0;
        res     = 32'h0;
        case (w[6:0])
            7'h37: begin wr = 1'b1; res = {w[31:12], 12'h000}; end
            7'h17: begin wr = 1'b1; res = mpc + {w[31:12], 12'h000}; end
            7'h6f: begin
                wr  = 1'b1;
                res = mpc + 32'd4;
                nxt = mpc + sext({11'h0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
            end
            7'h67: if (w[14:12] == 3'd0) begin
                wr  = 1'b1;
                res = mpc + 32'd4;
                nxt = (a + sext({20'h0, w[31:20]}, 12)) & 32'hFFFF_FFFE;
            end
            7'h63: begin
                case (w[14:12])
                    3'd0:    take = (a == b);
                    3'd1:    take = (a != b);
                    3'd4:    take = ($signed(a) <  $signed(b));
                    3'd5:    take = ($signed(a) >= $signed(b));
                    3'd6:    take = (a <  b);
                    3'd7:    take = (a >= b);
                    default: take = 1'b0;
                endcase
                if (take) nxt = mpc + sext({19'h0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
            end
            7'h13, 7'h33: begin
                regop   = (w[6:0] == 7'h33);
                opb     = regop ? b : sext({20'h0, w[31:20]}, 12);
                sh      = opb[4:0];
                f7_zero = (w[31:25] == 7'h00);
                f7_alt  = (w[31:25] == 7'h20);
                wr      = !regop || f7_zero;
                case (w[14:12])
                    3'd0: begin
                        if (regop && f7_alt) begin res = a - opb; wr = 1'b1; end
                        else res = a + opb;
                    end
                    3'd1: begin res = a << sh; wr = f7_zero; end
                    3'd2: res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < opb) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ opb;
                    3'd5: begin
                        res = f7_alt ? 32'($signed(a) >>> sh) : (a >> sh);
                        wr  = f7_zero || f7_alt;
                    end
                    3'd6: res = a | opb;
                    default: res = a & opb;
                endcase
            end
            default: wr = 1'b0;
        endcase
        if (wr && rd != 5'd0) mregs[rd] = res;
        mpc = nxt;
    endtask

    // ---------------- scoreboard producers ----------------
    task automatic push_state(input int c, input string tag);
        exp_t e;
        e.cyc = c; e.tag = tag; e.kind = 0; e.idx = 0; e.val = mpc; e.rf = '0;
        q.push_back(e);
        e.kind = 2;
        for (int i = 0; i < 32; i++) e.rf[i] = mregs[i];
        q.push_back(e);
    endtask

    task automatic expect_reg(input int c, input string tag, input int idx, input logic [31:0] v);
        exp_t e;
        e.cyc = c; e.tag = tag; e.kind = 1; e.idx = idx; e.val = v; e.rf = '0;
        q.push_back(e);
    endtask

    task automatic expect_pc(input int c, input string tag, input logic [31:0] v);
        exp_t e;
        e.cyc = c; e.tag = tag; e.kind = 0; e.idx = 0; e.val = v; e.rf = '0;
        q.push_back(e);
    endtask

    task automatic predict(input int ncyc, input string tag);
        mpc = 32'h0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        push_state(0, tag);
        for (int c = 1; c <= ncyc; c++) begin
            mstep();
            push_state(c, tag);
        end
    endtask

    // put the core into reset, optionally reload the ROM, and queue the model's predictions
    task automatic start_prog(input logic [31:0] p[$], input bit reload, input int ncyc,
                              input string tag);
        @(posedge clk);
        #1 rst = 1'b0;
        if (reload) begin
            for (int i = 0; i < ROM_DEPTH; i++) begin
                trom[i] = NOP;
                dut.rom_ins.rom_mem[i] = NOP;
            end
            foreach (p[i]) begin
                trom[i] = p[i];
                dut.rom_ins.rom_mem[i] = p[i];
            end
        end
        predict(ncyc, tag);
    endtask

    // release reset, run, then wait (bounded) for the monitor to drain the scoreboard
    task automatic finish_prog(input int ncyc, input string tag);
        @(negedge clk);
        rst = 1'b1;
        repeat (ncyc) @(posedge clk);
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s drain: got %0d pending want 0", tag, q.size());
            q.delete();
        end
    endtask

    function automatic logic [31:0] rand_insn();
        int          k;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        int          off;
        logic [2:0]  bf3 [6];
        logic [6:0]  nop_ops [4];
        bf3     = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        nop_ops = '{7'h03, 7'h23, 7'h0f, 7'h73};
        k   = $urandom_range(0, 9);
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        off = $urandom_range(0, 11) - 6;
        if (off == 0) off = 2;
        case (k)
            0: return u_t(7'h37, rd, 20'($urandom));
            1: return u_t(7'h17, rd, 20'($urandom));
            2, 3: begin
                if (f3 == 3'd1) return i_t(7'h13, rd, f3, rs1, {7'h00, rs2});
                if (f3 == 3'd5) return i_t(7'h13, rd, f3, rs1,
                                           {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2});
                return i_t(7'h13, rd, f3, rs1, 12'($urandom));
            end
            4, 5: return r_t(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                             rs2, rs1, f3, rd);
            6: return b_t(bf3[$urandom_range(0, 5)], rs1, rs2, 13'(off * 4));
            7: return j_t(rd, 21'(off * 4));
            8: return i_t(7'h67, rd, 3'd0, rs1, 12'($urandom_range(0, 64)));
            default: return {25'($urandom), nop_ops[$urandom_range(0, 3)]};
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] p[$];

        rst = 1'b0;
        repeat (3) @(posedge clk);

        // all-NOP ROM: pc steps by 4, registers stay 0
        p = {};
        start_prog(p, 1'b1, 10, "nop");
        expect_pc(0, "nop_reset_pc", 32'h0);
        expect_pc(10, "nop_pc10", 32'd40);
        finish_prog(10, "nop");

        // ADDI/ADDI/ADD
        p = {i_t(7'h13, 5'd27, 3'd0, 5'd0, 12'd5),
             i_t(7'h13, 5'd28, 3'd0, 5'd0, 12'd7),
             r_t(7'h00, 5'd28, 5'd27, 3'd0, 5'd29)};
        start_prog(p, 1'b1, 4, "add");
        expect_reg(3, "add_x27", 27, 32'd5);
        expect_reg(3, "add_x28", 28, 32'd7);
        expect_reg(3, "add_x29", 29, 32'd12);
        finish_prog(4, "add");

        // LUI / wrap-around ADDI / SUB
        p = {u_t(7'h37, 5'd28, 20'h80000),
             i_t(7'h13, 5'd29, 3'd0, 5'd28, 12'hFFF),
             r_t(7'h20, 5'd29, 5'd0, 3'd0, 5'd27)};
        start_prog(p, 1'b1, 4, "wrap");
        expect_reg(3, "lui_x28", 28, 32'h8000_0000);
        expect_reg(3, "wrap_x29", 29, 32'h7FFF_FFFF);
        expect_reg(3, "sub_x27", 27, 32'h8000_0001);
        finish_prog(4, "wrap");

        // branch not-taken / taken, JAL self-loop
        p = {i_t(7'h13, 5'd27, 3'd0, 5'd0, 12'd1),
             b_t(3'd0, 5'd27, 5'd0, 13'd8),
             i_t(7'h13, 5'd28, 3'd0, 5'd0, 12'd3),
             b_t(3'd1, 5'd27, 5'd0, 13'd8),
             i_t(7'h13, 5'd28, 3'd0, 5'd0, 12'd9),
             j_t(5'd29, 21'd0)};
        start_prog(p, 1'b1, 8, "branch");
        expect_reg(8, "br_x28", 28, 32'd3);
        expect_reg(8, "jal_link", 29, 32'd24);
        expect_pc(8, "jal_spin", 32'd20);
        finish_prog(8, "branch");

        // asynchronous reset mid-program, then rerun
        start_prog(p, 1'b0, 8, "midrst");
        expect_pc(0, "async_pc", 32'h0);
        expect_reg(0, "async_x27", 27, 32'h0);
        expect_reg(6, "rerun_x29", 29, 32'd24);
        finish_prog(8, "midrst");

        // x0 writes discarded
        p = {i_t(7'h13, 5'd27, 3'd0, 5'd0, 12'd77),
             i_t(7'h13, 5'd0, 3'd0, 5'd0, 12'd42),
             r_t(7'h00, 5'd0, 5'd0, 3'd0, 5'd27)};
        start_prog(p, 1'b1, 4, "x0");
        expect_reg(1, "x0_pre", 27, 32'd77);
        expect_reg(2, "x0_stays0", 0, 32'h0);
        expect_reg(3, "x0_reads0", 27, 32'h0);
        finish_prog(4, "x0");

        // JALR target LSB cleared, fetch address wraps past ROM_DEPTH
        p = {u_t(7'h37, 5'd1, 20'h00004),
             i_t(7'h67, 5'd5, 3'd0, 5'd1, 12'd9),
             i_t(7'h13, 5'd2, 3'd0, 5'd0, 12'd11),
             i_t(7'h13, 5'd3, 3'd0, 5'd2, 12'd1)};
        start_prog(p, 1'b1, 5, "romwrap");
        expect_pc(2, "jalr_target", 32'h0000_4008);
        expect_reg(2, "jalr_link", 5, 32'd8);
        expect_reg(3, "wrap_fetch", 2, 32'd11);
        expect_reg(4, "wrap_next", 3, 32'd12);
        finish_prog(5, "romwrap");

        // randomized programs against the model
        for (int r = 0; r < 5; r++) begin
            p = {};
            for (int i = 0; i < 64; i++) p.push_back(rand_insn());
            start_prog(p, 1'b1, 150, $sformatf("rand%0d", r));
            finish_prog(150, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule
